// File: rtl/pipeline_stage_skid.sv
// Generic pipeline stage register: one main slot plus one skid slot with valid/ready
// handshaking, flush-to-bubble, and saturating bubble/stall counters.
module pipeline_stage_skid #(
    parameter int DATA_W = 104,
    parameter int CTRL_W = 13,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] InData,
    input  logic [CTRL_W-1:0] InCtrl,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutData,
    output logic [CTRL_W-1:0] OutCtrl,
    output logic [CNT_W-1:0]  BubbleCount,
    output logic [CNT_W-1:0]  StallCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              mainValid;
    logic [DATA_W-1:0] mainData;
    logic [CTRL_W-1:0] mainCtrl;
    logic              skidValid;
    logic [DATA_W-1:0] skidData;
    logic [CTRL_W-1:0] skidCtrl;

    logic inXfer;
    logic outXfer;
    logic mainAdvance;

    assign inXfer      = InValid & ~skidValid;
    assign outXfer     = mainValid & OutReady;
    assign mainAdvance = ~mainValid | outXfer;

    // The skid flag is itself a flop, so InReady is a registered output.
    assign InReady  = ~skidValid;
    assign OutValid = mainValid;
    assign OutData  = mainData;
    assign OutCtrl  = mainCtrl;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mainValid   <= 1'b0;
            mainData    <= '0;
            mainCtrl    <= '0;
            skidValid   <= 1'b0;
            skidData    <= '0;
            skidCtrl    <= '0;
            BubbleCount <= '0;
            StallCount  <= '0;
        end else begin
            if (!mainValid && BubbleCount != CNT_MAX) begin
                BubbleCount <= BubbleCount + CNT_ONE;
            end
            // A flushed head is dropped regardless of OutReady, so it is not a stall.
            if (mainValid && !OutReady && !Flush && StallCount != CNT_MAX) begin
                StallCount <= StallCount + CNT_ONE;
            end

            if (Flush) begin
                mainValid <= 1'b0;
                mainCtrl  <= '0;
                skidValid <= 1'b0;
            end else begin
                if (mainAdvance) begin
                    if (skidValid) begin
                        mainValid <= 1'b1;
                        mainData  <= skidData;
                        mainCtrl  <= skidCtrl;
                    end else if (inXfer) begin
                        mainValid <= 1'b1;
                        mainData  <= InData;
                        mainCtrl  <= InCtrl;
                    end else begin
                        // Empty slot presents a NOP; data is left as-is.
                        mainValid <= 1'b0;
                        mainCtrl  <= '0;
                    end
                end

                if (mainAdvance && skidValid) begin
                    skidValid <= 1'b0;
                end else if (inXfer && mainValid && !outXfer) begin
                    skidValid <= 1'b1;
                    skidData  <= InData;
                    skidCtrl  <= InCtrl;
                end
            end
        end
    end

endmodule
